sqrt_arbiter: RTL and testbench

//  Shares one psdsqrt unit between NREQ requesters using round-robin arbitration.

---
 rtl/sqrt_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sqrt_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// sqrt_arbiter
//   Shares a single psdsqrt unit between NREQ requesters with round-robin
//   arbitration. The winner's argument is latched, a one-cycle run pulse is sent
//   to the unit, busy is tracked through its rise and fall, and the result is
//   captured and returned with a one-cycle done pulse to the winner.
//
//   Sequence: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> DELIVER -> IDLE
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  cycles allowed in WAIT_BUSY + WAIT_DONE before abort
//
// Optional feature macro: SQRT_ARB_TIMEOUT_EN
//   defined   : watchdog aborts a stuck operation, returns 16'hFFFF, sets err
//   undefined : WAIT states wait indefinitely, err tied to 0
//
// Ports
//   clock        in   master clock
//   reset        in   asynchronous reset, active low
//   req          in   per-requester request, held until its done pulse
//   xin_bus      in   argument of requester i at [32*i+31:32*i]
//   grant        out  one-hot, winner from LAUNCH through DELIVER
//   done         out  one-cycle pulse to the winner, sqrt_out valid then
//   sqrt_out     out  captured square root, holds until next capture
//   err          out  sticky timeout flag
//   sqrt_run     out  one-cycle start pulse to psdsqrt
//   sqrt_xin     out  argument to psdsqrt, stable for the whole operation
//   sqrt_busy    in   busy from psdsqrt
//   sqrt_result  in   result from psdsqrt
// -----------------------------------------------------------------------------
module sqrt_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   xin_bus,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic [15:0]          sqrt_out,
   output logic                 err,
   output logic                 sqrt_run,
   output logic [31:0]          sqrt_xin,
   input  logic                 sqrt_busy,
   input  logic [15:0]          sqrt_result
);

   localparam int IDX_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("sqrt_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_DELIVER
   } state_t;

   state_t              r_state;
   logic [NREQ-1:0]     r_grant;
   logic [NREQ-1:0]     r_done;
   logic                r_run;
   logic [31:0]         r_xin;
   logic [15:0]         r_out;
   logic [IDX_W-1:0]    r_last;

   logic                w_any;
   logic [IDX_W-1:0]    w_winner;
   logic [NREQ-1:0]     w_onehot;
   logic [31:0]         w_xin_sel;

`ifdef SQRT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]    r_cnt;
   logic                r_err;
   logic                w_expired;

   // Last permitted wait cycle; the abort takes effect on this edge so the
   // operation spends exactly TIMEOUT cycles in the WAIT states.
   assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

   // Round-robin pick: scan last+1, last+2, ... and take the first active req,
   // so the previous winner ends up with the lowest priority.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      w_any    = 1'b0;
      w_winner = r_last;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_any && req[(int'(r_last) + k) % NREQ]) begin
            w_any    = 1'b1;
            w_winner = IDX_W'((int'(r_last) + k) % NREQ);
         end
      end
      w_onehot           = '0;
      w_onehot[w_winner] = 1'b1;
      w_xin_sel          = xin_bus[32*int'(w_winner) +: 32];
   end

   // NOTE: state is updated with non-blocking assignments only, so every branch
   // below reads the values from before this edge.
   // NOTE: the asynchronous reset clears every register, including the latched
   // argument and result, so an aborted operation leaves nothing behind.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_done  <= '0;
         r_run   <= 1'b0;
         r_xin   <= '0;
         r_out   <= '0;
         r_last  <= IDX_W'(NREQ - 1);
`ifdef SQRT_ARB_TIMEOUT_EN
         r_cnt   <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
         // run and done are single-cycle pulses
         r_run  <= 1'b0;
         r_done <= '0;

         case (r_state)
            S_IDLE: begin
               // A busy unit (e.g. after an arbiter-only reset) must finish first.
               if (w_any && !sqrt_busy) begin
                  r_grant <= w_onehot;
                  r_xin   <= w_xin_sel;
                  r_last  <= w_winner;
                  r_run   <= 1'b1;
                  r_state <= S_LAUNCH;
               end
            end

            S_LAUNCH: begin
`ifdef SQRT_ARB_TIMEOUT_EN
               r_cnt   <= '0;
`endif
               r_state <= S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
`ifdef SQRT_ARB_TIMEOUT_EN
               if (w_expired) begin
                  r_out   <= 16'hFFFF;
                  r_err   <= 1'b1;
                  r_done  <= r_grant;
                  r_state <= S_DELIVER;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (sqrt_busy) r_state <= S_WAIT_DONE;
               end
`else
               if (sqrt_busy) r_state <= S_WAIT_DONE;
`endif
            end

            S_WAIT_DONE: begin
               // A genuine completion wins over a coincident watchdog expiry.
               if (!sqrt_busy) begin
                  r_out   <= sqrt_result;
                  r_done  <= r_grant;
                  r_state <= S_DELIVER;
               end
`ifdef SQRT_ARB_TIMEOUT_EN
               else if (w_expired) begin
                  r_out   <= 16'hFFFF;
                  r_err   <= 1'b1;
                  r_done  <= r_grant;
                  r_state <= S_DELIVER;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end

            S_DELIVER: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end

            default: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign grant    = r_grant;
   assign done     = r_done;
   assign sqrt_run = r_run;
   assign sqrt_xin = r_xin;
   assign sqrt_out = r_out;
`ifdef SQRT_ARB_TIMEOUT_EN
   assign err      = r_err;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sqrt_arbiter
//   Self-checking bench for sqrt_arbiter (NREQ = 4). A behavioural psdsqrt
//   model answers run pulses after a programmable busy time; expected results
//   come from a floating-point square root, expected winners from the
//   round-robin rule applied to the request vector the bench drives.
// -----------------------------------------------------------------------------
module tb_sqrt_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;

   logic                clock = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [32*NREQ-1:0]  xin_bus;
   logic [NREQ-1:0]     grant;
   logic [NREQ-1:0]     done;
   logic [15:0]         sqrt_out;
   logic                err;
   logic                sqrt_run;
   logic [31:0]         sqrt_xin;
   logic                sqrt_busy;
   logic [15:0]         sqrt_result;

   int n_checks = 0;
   int n_fail   = 0;
   int ref_last = NREQ - 1;

   sqrt_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .xin_bus     (xin_bus),
      .grant       (grant),
      .done        (done),
      .sqrt_out    (sqrt_out),
      .err         (err),
      .sqrt_run    (sqrt_run),
      .sqrt_xin    (sqrt_xin),
      .sqrt_busy   (sqrt_busy),
      .sqrt_result (sqrt_result)
   );

   always #5 clock = ~clock;

   // ---------------- reference helpers ----------------
   function automatic logic [15:0] isqrt(input logic [31:0] x);
      longint r;
      r = longint'($floor($sqrt(real'(x))));
      while (r * r > longint'(x)) r--;
      while ((r + 1) * (r + 1) <= longint'(x)) r++;
      return 16'(r);
   endfunction

   function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++)
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [31:0] rand_x();
      case ($urandom_range(0, 3))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'($urandom_range(0, 300));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- psdsqrt behavioural model ----------------
   // Busy rises the cycle after run and stays high m_lat+1 cycles; the result
   // is garbage while busy and becomes valid as busy falls.
   logic        m_dead = 1'b0;
   int          m_lat  = 3;
   logic        m_busy = 1'b0;
   int          m_cnt  = 0;
   logic [31:0] m_x    = '0;
   logic [15:0] m_res  = '0;

   always @(posedge clock) begin
      if (m_busy) begin
         if (m_cnt == 0) begin
            m_busy <= 1'b0;
            m_res  <= isqrt(m_x);
         end else begin
            m_cnt  <= m_cnt - 1;
            m_res  <= 16'($urandom);
         end
      end else if (sqrt_run && !m_dead) begin
         m_busy <= 1'b1;
         m_cnt  <= m_lat;
         m_x    <= sqrt_xin;
      end
   end

   assign sqrt_busy   = m_busy;
   assign sqrt_result = m_res;

   // ---------------- check and wait tasks ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_busy_level(input logic lvl, input string tag);
      int n = 0;
      while (sqrt_busy !== lvl && n < 300) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(sqrt_busy === lvl), 32'd1);
   endtask

   task automatic wait_run(input string tag);
      int  n    = 0;
      bit  seen = 1'b0;
      while (!seen && n < 50) begin
         @(negedge clock);
         n++;
         if (sqrt_run === 1'b1) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   // Waits for the next done pulse and checks who got it and with what.
   task automatic expect_done(input int idx, input logic [31:0] x, input logic [15:0] res,
                              input string tag, output int cycles);
      int  n    = 0;
      bit  seen = 1'b0;
      while (!seen && n < 400) begin
         @(negedge clock);
         n++;
         if (done !== '0) seen = 1'b1;
      end
      check($sformatf("%s.done_seen", tag), 32'(seen), 32'd1);
      if (seen) begin
         check($sformatf("%s.done", tag),  32'(done),     32'(1 << idx));
         check($sformatf("%s.grant", tag), 32'(grant),    32'(1 << idx));
         check($sformatf("%s.out", tag),   32'(sqrt_out), 32'(res));
         check($sformatf("%s.xin", tag),   sqrt_xin,      x);
      end
      ref_last = idx;
      cycles   = n;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          cyc;
      int          win;
      logic [31:0] x;
      logic [3:0]  newm;

      reset   = 1'b0;
      req     = '0;
      xin_bus = '0;
      repeat (3) @(negedge clock);

      // Reset state
      check("rst.grant", 32'(grant), 32'd0);
      check("rst.done",  32'(done),  32'd0);
      check("rst.run",   32'(sqrt_run), 32'd0);
      check("rst.err",   32'(err),   32'd0);
      check("rst.xin",   sqrt_xin,   32'd0);
      check("rst.out",   32'(sqrt_out), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      check("idle.run", 32'(sqrt_run), 32'd0);

      // 1: single request, run one cycle after req, 144 -> 12
      m_lat              = 5;
      xin_bus[31:0]      = 32'd144;
      req                = 4'b0001;
      @(negedge clock);
      check("t1.run",   32'(sqrt_run), 32'd1);
      check("t1.grant", 32'(grant),    32'd1);
      check("t1.xin",   sqrt_xin,      32'd144);
      @(negedge clock);
      check("t1.run_pulse", 32'(sqrt_run), 32'd0);
      expect_done(0, 32'd144, 16'd12, "t1", cyc);
      // total latency 3 + busy length (m_lat+1), two cycles already consumed
      check("t1.latency", 32'(cyc), 32'(3 + (m_lat + 1) - 2));
      req = '0;
      @(negedge clock);
      check("t1.done_clear",  32'(done),  32'd0);
      check("t1.grant_clear", 32'(grant), 32'd0);

      // 2: all four request from reset -> served 0,1,2,3
      reset = 1'b0;
      @(negedge clock);
      reset    = 1'b1;
      ref_last = NREQ - 1;
      xin_bus  = {32'd2, 32'hFFFF_FFFF, 32'd1000000, 32'd0};
      req      = 4'b1111;
      m_lat    = $urandom_range(0, 6);
      expect_done(0, 32'd0,          16'd0,     "t2.r0", cyc); req[0] = 1'b0;
      expect_done(1, 32'd1000000,    16'd1000,  "t2.r1", cyc); req[1] = 1'b0;
      expect_done(2, 32'hFFFF_FFFF,  16'd65535, "t2.r2", cyc); req[2] = 1'b0;
      expect_done(3, 32'd2,          16'd1,     "t2.r3", cyc); req[3] = 1'b0;

      // 3: req[2] held, req[1] raised mid-service -> 2, 1, 2
      x                 = rand_x();
      xin_bus[64 +: 32] = x;
      req               = 4'b0100;
      wait_busy_level(1'b1, "t3.busy");
      xin_bus[32 +: 32] = 32'd625;
      req[1]            = 1'b1;
      expect_done(2, x, isqrt(x), "t3.a", cyc);
      expect_done(1, 32'd625, 16'd25, "t3.b", cyc);
      req[1] = 1'b0;
      expect_done(2, x, isqrt(x), "t3.c", cyc);
      req = '0;

      // 4: req[3] dropped in WAIT_DONE, service still completes, 81 -> 9
      m_lat              = 8;
      xin_bus[96 +: 32]  = 32'd81;
      req                = 4'b1000;
      wait_busy_level(1'b1, "t4.busy");
      @(negedge clock);
      req = '0;
      expect_done(3, 32'd81, 16'd9, "t4", cyc);
      repeat (4) begin
         @(negedge clock);
         check("t4.no_rerun", 32'(sqrt_run | |done), 32'd0);
      end

      // 5: reset during WAIT_DONE with the unit busy
      m_lat          = 20;
      x              = rand_x();
      xin_bus[31:0]  = x;
      req            = 4'b0001;
      wait_busy_level(1'b1, "t5.busy");
      @(negedge clock);
      #1 reset = 1'b0;
      #1;
      check("t5.grant", 32'(grant),    32'd0);
      check("t5.done",  32'(done),     32'd0);
      check("t5.run",   32'(sqrt_run), 32'd0);
      check("t5.xin",   sqrt_xin,      32'd0);
      check("t5.out",   32'(sqrt_out), 32'd0);
      check("t5.err",   32'(err),      32'd0);
      @(negedge clock);
      reset    = 1'b1;
      ref_last = NREQ - 1;
      cyc      = 0;
      while (sqrt_busy && cyc < 100) begin
         @(negedge clock);
         cyc++;
         check("t5.hold_off", 32'(sqrt_run | |done), 32'd0);
      end
      check("t5.unit_idle", 32'(sqrt_busy), 32'd0);
      expect_done(0, x, isqrt(x), "t5.resume", cyc);
      req = '0;

      // Random traffic against the round-robin reference
      for (int it = 0; it < 24; it++) begin
         logic [31:0] wx;
         if (req == '0) begin
            newm = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++)
               if (newm[i]) xin_bus[32*i +: 32] = rand_x();
            req = newm;
         end
         m_lat = $urandom_range(0, 10);
         win   = rr_pick(ref_last, req);
         wx    = xin_bus[32*win +: 32];
         wait_run($sformatf("rnd%0d.run", it));
         // argument already latched: disturbing it must not matter
         xin_bus[32*win +: 32] = $urandom;
         newm = 4'($urandom) & ~req;
         for (int i = 0; i < NREQ; i++)
            if (newm[i]) xin_bus[32*i +: 32] = rand_x();
         req = req | newm;
         expect_done(win, wx, isqrt(wx), $sformatf("rnd%0d", it), cyc);
         if ($urandom_range(0, 2) != 0) req[win] = 1'b0;
      end
      req = '0;
      repeat (30) @(negedge clock);

`ifdef SQRT_ARB_TIMEOUT_EN
      // 6: unit never answers -> abort after TIMEOUT wait cycles
      m_dead            = 1'b1;
      xin_bus[32 +: 32] = 32'd49;
      req               = 4'b0010;
      expect_done(1, 32'd49, 16'hFFFF, "t6", cyc);
      // LAUNCH, TIMEOUT wait cycles, then DELIVER
      check("t6.latency", 32'(cyc), 32'(TIMEOUT + 2));
      check("t6.err", 32'(err), 32'd1);
      req = '0;
      repeat (3) @(negedge clock);
      check("t6.err_sticky", 32'(err), 32'd1);
      m_dead = 1'b0;
`else
      check("err.disabled", 32'(err), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
